// File: rtl/iir_coeff_bank.sv
// Double-buffered biquad coefficient store: host writes to a shadow bank,
// atomic commit/swap at a datapath safe point, then shadow re-synced.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ld_valid/ld_ready        host write handshake (ld_sos, ld_sel, ld_data)
//   commit, swap_ok          swap request and datapath safe point
//   pending, swap_done       swap status (swap_done is a 1-cycle pulse)
//   bank_sel                 index of the active bank
//   ld_err                   sticky out-of-range write flag
//   rd_en, rd_sos            registered read request
//   rd_valid, b0..a2         read response, one cycle after request
module iir_coeff_bank #(
  parameter int COEF_W  = 24,
  parameter int NUM_SOS = 4,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_sos,
  input  logic [2:0]        ld_sel,
  input  logic [COEF_W-1:0] ld_data,
  input  logic              commit,
  input  logic              swap_ok,
  output logic              pending,
  output logic              swap_done,
  output logic              bank_sel,
  output logic              ld_err,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_sos,
  output logic              rd_valid,
  output logic [COEF_W-1:0] b0,
  output logic [COEF_W-1:0] b1,
  output logic [COEF_W-1:0] b2,
  output logic [COEF_W-1:0] a1,
  output logic [COEF_W-1:0] a2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_COPY
  } state_t;

  // Default set held as 24-bit Q2.22; rescaled by keeping the MSB side so
  // the integer bits survive any COEF_W.
  function automatic logic [COEF_W-1:0] def_coef(int s, int k);
    logic [23:0]        v;
    logic [23:0]        b1v;
    logic [23:0]        a1v;
    logic [23:0]        a2v;
    logic [COEF_W+23:0] w;
    b1v = 24'h0;
    a1v = 24'h0;
    a2v = 24'h0;
    case (s)
      0: begin
        b1v = 24'h010CC5;
        a1v = 24'hE08C0C;
        a2v = 24'h31A0FF;
      end
      1: begin
        b1v = 24'h09E05D;
        a1v = 24'hEDDA8D;
        a2v = 24'h1B7A91;
      end
      2: begin
        b1v = 24'h1C9720;
        a1v = 24'hFC035E;
        a2v = 24'h0B0A64;
      end
      3: begin
        b1v = 24'h32269C;
        a1v = 24'h05A195;
        a2v = 24'h017AD4;
      end
      default: begin
        b1v = 24'h0;
        a1v = 24'h0;
        a2v = 24'h0;
      end
    endcase
    case (k)
      0, 2:    v = (s < 4) ? 24'h1B0F47 : 24'h0;
      1:       v = b1v;
      3:       v = a1v;
      4:       v = a2v;
      default: v = 24'h0;
    endcase
    w = {v, {COEF_W{1'b0}}};
    return w[COEF_W+23 -: COEF_W];
  endfunction

  state_t            state_q, state_d;
  logic              bank_sel_q, bank_sel_d;
  logic              swap_done_q, swap_done_d;
  logic              ld_err_q, ld_err_d;
  logic [IDX_W-1:0]  copy_idx_q, copy_idx_d;
  logic              rd_valid_q, rd_valid_d;
  logic [COEF_W-1:0] b0_q, b0_d;
  logic [COEF_W-1:0] b1_q, b1_d;
  logic [COEF_W-1:0] b2_q, b2_d;
  logic [COEF_W-1:0] a1_q, a1_d;
  logic [COEF_W-1:0] a2_q, a2_d;
  logic [COEF_W-1:0] bank_q [2][NUM_SOS][5];
  logic [COEF_W-1:0] bank_d [2][NUM_SOS][5];

  logic sh;
  logic ld_bad;
  logic rd_in;
  logic copy_last;

  assign sh        = ~bank_sel_q;
  assign ld_bad    = (32'(ld_sos) >= NUM_SOS) || (ld_sel > 3'd4);
  assign rd_in     = 32'(rd_sos) < NUM_SOS;
  assign copy_last = 32'(copy_idx_q) == NUM_SOS - 1;

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    swap_done_d = 1'b0;
    ld_err_d    = ld_err_q;
    copy_idx_d  = copy_idx_q;
    bank_d      = bank_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          if (ld_bad) begin
            ld_err_d = 1'b1;
          end else begin
            bank_d[sh][ld_sos][ld_sel] = ld_data;
          end
        end
        if (commit) begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (swap_ok) begin
          bank_sel_d  = ~bank_sel_q;
          swap_done_d = 1'b1;
          copy_idx_d  = '0;
          state_d     = S_COPY;
        end
      end
      S_COPY: begin
        // bank_sel_q already names the new active bank here.
        for (int k = 0; k < 5; k++) begin
          bank_d[sh][copy_idx_q][k] =
            bank_q[bank_sel_q][copy_idx_q][k];
        end
        if (copy_last) begin
          state_d = S_IDLE;
        end else begin
          copy_idx_d = copy_idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read uses pre-edge bank_sel_q, so a read on the swap edge sees
  // the outgoing active bank.
  always_comb begin
    rd_valid_d = 1'b0;
    b0_d = b0_q;
    b1_d = b1_q;
    b2_d = b2_q;
    a1_d = a1_q;
    a2_d = a2_q;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (rd_in) begin
        b0_d = bank_q[bank_sel_q][rd_sos][0];
        b1_d = bank_q[bank_sel_q][rd_sos][1];
        b2_d = bank_q[bank_sel_q][rd_sos][2];
        a1_d = bank_q[bank_sel_q][rd_sos][3];
        a2_d = bank_q[bank_sel_q][rd_sos][4];
      end else begin
        b0_d = '0;
        b1_d = '0;
        b2_d = '0;
        a1_d = '0;
        a2_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bank_sel_q  <= 1'b0;
      swap_done_q <= 1'b0;
      ld_err_q    <= 1'b0;
      copy_idx_q  <= '0;
      rd_valid_q  <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < NUM_SOS; s++) begin
          for (int k = 0; k < 5; k++) begin
            bank_q[b][s][k] <= def_coef(s, k);
          end
        end
      end
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      swap_done_q <= swap_done_d;
      ld_err_q    <= ld_err_d;
      copy_idx_q  <= copy_idx_d;
      rd_valid_q  <= rd_valid_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      bank_q      <= bank_d;
    end
  end

  assign ld_ready  = state_q == S_IDLE;
  assign pending   = state_q == S_PEND;
  assign swap_done = swap_done_q;
  assign bank_sel  = bank_sel_q;
  assign ld_err    = ld_err_q;
  assign rd_valid  = rd_valid_q;
  assign b0        = b0_q;
  assign b1        = b1_q;
  assign b2        = b2_q;
  assign a1        = a1_q;
  assign a2        = a2_q;

endmodule

// File: tb/tb_iir_coeff_bank.sv
// Self-checking bench for iir_coeff_bank against a two-array
// (active/shadow) behavioural model.
module tb_iir_coeff_bank;
  localparam int COEF_W  = 24;
  localparam int NUM_SOS = 4;
  localparam int IDX_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [IDX_W-1:0]  ld_sos = '0;
  logic [2:0]        ld_sel = '0;
  logic [COEF_W-1:0] ld_data = '0;
  logic              commit = 1'b0;
  logic              swap_ok = 1'b0;
  logic              pending;
  logic              swap_done;
  logic              bank_sel;
  logic              ld_err;
  logic              rd_en = 1'b0;
  logic [IDX_W-1:0]  rd_sos = '0;
  logic              rd_valid;
  logic [COEF_W-1:0] b0, b1, b2, a1, a2;

  iir_coeff_bank #(
    .COEF_W(COEF_W), .NUM_SOS(NUM_SOS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sos(ld_sos), .ld_sel(ld_sel), .ld_data(ld_data),
    .commit(commit), .swap_ok(swap_ok),
    .pending(pending), .swap_done(swap_done),
    .bank_sel(bank_sel), .ld_err(ld_err),
    .rd_en(rd_en), .rd_sos(rd_sos), .rd_valid(rd_valid),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] m_act [NUM_SOS][5];
  logic [23:0] m_sh  [NUM_SOS][5];
  logic        m_err;
  logic        m_bank;

  task automatic model_reset();
    logic [23:0] tb1 [4];
    logic [23:0] ta1 [4];
    logic [23:0] ta2 [4];
    tb1 = '{24'h010CC5, 24'h09E05D, 24'h1C9720, 24'h32269C};
    ta1 = '{24'hE08C0C, 24'hEDDA8D, 24'hFC035E, 24'h05A195};
    ta2 = '{24'h31A0FF, 24'h1B7A91, 24'h0B0A64, 24'h017AD4};
    for (int s = 0; s < NUM_SOS; s++) begin
      if (s < 4) begin
        m_act[s] = '{24'h1B0F47, tb1[s], 24'h1B0F47, ta1[s], ta2[s]};
      end else begin
        m_act[s] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
      end
      m_sh[s] = m_act[s];
    end
    m_err  = 1'b0;
    m_bank = 1'b0;
  endtask

  // After a swap the shadow is re-synced, so both hold the committed set.
  task automatic model_swap();
    m_act  = m_sh;
    m_bank = ~m_bank;
  endtask

  function automatic logic [23:0] obs(int k);
    case (k)
      0:       return b0;
      1:       return b1;
      2:       return b2;
      3:       return a1;
      default: return a2;
    endcase
  endfunction

  function automatic logic [23:0] exp_rd(int s, int k);
    if (s >= NUM_SOS) return 24'h0;
    return m_act[s][k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int k, input logic [23:0] d);
    ld_valid = 1'b1;
    ld_sos   = IDX_W'(s);
    ld_sel   = 3'(k);
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
    if (s >= NUM_SOS || k > 4) m_err = 1'b1;
    else m_sh[s][k] = d;
  endtask

  task automatic rd(input int s);
    rd_en  = 1'b1;
    rd_sos = IDX_W'(s);
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ld_ready && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic swap_seq(input int waits, output int n);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (waits) tick();
    swap_ok = 1'b1;
    tick();
    swap_ok = 1'b0;
    model_swap();
    wait_ready(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({ld_ready, pending, swap_done, bank_sel, ld_err, rd_valid}
        !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 100000",
        {ld_ready, pending, swap_done, bank_sel, ld_err, rd_valid});
    end
    n_tests++;
    if ({b0, b1, b2, a1, a2} !== '0) begin
      n_fail++;
      $display("FAIL reset_coef got %h want 0", {b0, b1, b2, a1, a2});
    end
    rst = 1'b0;
    model_reset();
    rd_en = 1'b1;
    for (int s = 0; s < NUM_SOS; s++) begin
      rd_sos = IDX_W'(s);
      tick();
      n_tests++;
      if (rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_valid s%0d got %b want 1", s, rd_valid);
      end
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (obs(k) !== exp_rd(s, k)) begin
          n_fail++;
          $display("FAIL b2b_rd s%0d k%0d got %h want %h",
            s, k, obs(k), exp_rd(s, k));
        end
      end
    end
    rd_en = 1'b0;
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || a2 !== 24'h017AD4 || bank_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_hold got v=%b a2=%h bs=%b want 0 017ad4 0",
        rd_valid, a2, bank_sel);
    end
  endtask

  task automatic test_write_commit();
    int n;
    wr(1, 1, 24'h123456);
    rd(1);
    n_tests++;
    if (b1 !== 24'h09E05D) begin
      n_fail++;
      $display("FAIL pre_swap_rd got %h want 09e05d", b1);
    end
    commit  = 1'b1;
    swap_ok = 1'b1;
    tick();
    commit = 1'b0;
    n_tests++;
    if ({pending, ld_ready, bank_sel} !== 3'b100) begin
      n_fail++;
      $display("FAIL commit_pend got %b want 100",
        {pending, ld_ready, bank_sel});
    end
    tick();
    swap_ok = 1'b0;
    model_swap();
    n_tests++;
    if ({bank_sel, swap_done, pending} !== 3'b110) begin
      n_fail++;
      $display("FAIL swap_edge got %b want 110",
        {bank_sel, swap_done, pending});
    end
    tick();
    n_tests++;
    if (swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pulse got %b want 0", swap_done);
    end
    wait_ready(n);
    n_tests++;
    if (n != NUM_SOS - 1) begin
      n_fail++;
      $display("FAIL copy_len got %0d want %0d", n, NUM_SOS - 1);
    end
    rd(1);
    n_tests++;
    if (b1 !== 24'h123456) begin
      n_fail++;
      $display("FAIL post_swap_rd got %h want 123456", b1);
    end
    swap_seq(0, n);
    n_tests++;
    if (bank_sel !== m_bank || n != NUM_SOS) begin
      n_fail++;
      $display("FAIL swap2 got bs=%b n=%0d want %b %0d",
        bank_sel, n, m_bank, NUM_SOS);
    end
    for (int s = 0; s < NUM_SOS; s++) begin
      rd(s);
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (obs(k) !== exp_rd(s, k)) begin
          n_fail++;
          $display("FAIL shadow_copy s%0d k%0d got %h want %h",
            s, k, obs(k), exp_rd(s, k));
        end
      end
    end
  endtask

  task automatic test_stall();
    int  n;
    logic bs0;
    bs0 = bank_sel;
    commit = 1'b1;
    tick();
    commit   = 1'b0;
    ld_valid = 1'b1;
    ld_sos   = '0;
    ld_sel   = 3'd0;
    ld_data  = 24'(~m_act[0][0]);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({pending, ld_ready, bank_sel} !== {2'b10, bs0}) begin
        n_fail++;
        $display("FAIL stall c%0d got %b want %b", i,
          {pending, ld_ready, bank_sel}, {2'b10, bs0});
      end
    end
    swap_ok  = 1'b1;
    ld_valid = 1'b0;
    tick();
    swap_ok = 1'b0;
    model_swap();
    n_tests++;
    if (bank_sel !== ~bs0 || swap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_swap got bs=%b sd=%b want %b 1",
        bank_sel, swap_done, ~bs0);
    end
    wait_ready(n);
    n_tests++;
    if (n != NUM_SOS) begin
      n_fail++;
      $display("FAIL stall_ready got %0d want %0d", n, NUM_SOS);
    end
    rd(0);
    n_tests++;
    if (b0 !== m_act[0][0]) begin
      n_fail++;
      $display("FAIL stall_nowrite got %h want %h", b0, m_act[0][0]);
    end
  endtask

  task automatic test_ld_err();
    int n;
    n_tests++;
    if (ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b want 0", ld_err);
    end
    wr(0, 5, 24'hABCDEF);
    wr(2, 7, 24'h555555);
    if (NUM_SOS < (1 << IDX_W)) wr(NUM_SOS, 0, 24'h111111);
    n_tests++;
    if (ld_err !== m_err) begin
      n_fail++;
      $display("FAIL err_set got %b want %b", ld_err, m_err);
    end
    swap_seq(2, n);
    for (int s = 0; s < NUM_SOS; s++) begin
      rd(s);
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (obs(k) !== exp_rd(s, k)) begin
          n_fail++;
          $display("FAIL err_rd s%0d k%0d got %h want %h",
            s, k, obs(k), exp_rd(s, k));
        end
      end
    end
    n_tests++;
    if (ld_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got %b want 1", ld_err);
    end
  endtask

  task automatic test_read_on_swap();
    int          n;
    logic [23:0] old_v;
    logic [23:0] d;
    d = 24'($urandom);
    wr(2, 3, d);
    old_v = m_act[2][3];
    commit = 1'b1;
    tick();
    commit  = 1'b0;
    swap_ok = 1'b1;
    rd_en   = 1'b1;
    rd_sos  = 2'd2;
    tick();
    swap_ok = 1'b0;
    model_swap();
    n_tests++;
    if (a1 !== old_v || bank_sel !== m_bank) begin
      n_fail++;
      $display("FAIL rd_on_swap got %h bs=%b want %h %b",
        a1, bank_sel, old_v, m_bank);
    end
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (a1 !== d) begin
      n_fail++;
      $display("FAIL rd_after_swap got %h want %h", a1, d);
    end
    wait_ready(n);
    d        = 24'($urandom);
    ld_valid = 1'b1;
    ld_sos   = 2'd3;
    ld_sel   = 3'd4;
    ld_data  = d;
    commit   = 1'b1;
    tick();
    ld_valid = 1'b0;
    commit   = 1'b0;
    m_sh[3][4] = d;
    n_tests++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_commit_pend got %b want 1", pending);
    end
    swap_ok = 1'b1;
    tick();
    swap_ok = 1'b0;
    model_swap();
    wait_ready(n);
    rd(3);
    n_tests++;
    if (a2 !== d) begin
      n_fail++;
      $display("FAIL wr_commit_rd got %h want %h", a2, d);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 6; w++) begin
        wr($urandom_range(NUM_SOS - 1), $urandom_range(5),
          24'($urandom));
      end
      swap_seq($urandom_range(3), n);
      n_tests++;
      if (n != NUM_SOS || bank_sel !== m_bank) begin
        n_fail++;
        $display("FAIL rnd_swap r%0d n=%0d bs=%b want %0d %b",
          r, n, bank_sel, NUM_SOS, m_bank);
      end
      for (int s = 0; s < NUM_SOS; s++) begin
        rd(s);
        for (int k = 0; k < 5; k++) begin
          n_tests++;
          if (obs(k) !== exp_rd(s, k)) begin
            n_fail++;
            $display("FAIL rnd_rd r%0d s%0d k%0d got %h want %h",
              r, s, k, obs(k), exp_rd(s, k));
          end
        end
      end
    end
  endtask

  task automatic test_rst_copy();
    int n;
    wr(2, 4, 24'h777777);
    swap_seq(0, n);
    commit = 1'b1;
    tick();
    commit  = 1'b0;
    swap_ok = 1'b1;
    tick();
    swap_ok = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bank_sel, pending, ld_ready, ld_err, rd_valid} !== 5'b00100) begin
      n_fail++;
      $display("FAIL rst_copy got %b want 00100",
        {bank_sel, pending, ld_ready, ld_err, rd_valid});
    end
    tick();
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < NUM_SOS; s++) begin
      rd(s);
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (obs(k) !== exp_rd(s, k)) begin
          n_fail++;
          $display("FAIL rst_rd s%0d k%0d got %h want %h",
            s, k, obs(k), exp_rd(s, k));
        end
      end
    end
    rd(2);
    n_tests++;
    if (a2 !== 24'h0B0A64) begin
      n_fail++;
      $display("FAIL rst_s2a2 got %h want 0b0a64", a2);
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_stall();
    test_ld_err();
    test_read_on_swap();
    test_random();
    test_rst_copy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
